// File: rtl/crc5_r.sv
// Receive-side token/handshake checker: PID complement, packet length and CRC5
// validation, address filtering, and a one-cycle accept/error pulse per packet.
module crc5_r #(
    parameter int unsigned TOKEN_LEN = 3,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ms,
    input  logic [6:0]           dev_addr,
    input  logic                 rx_handshake_on,
    input  logic                 rx_sop,
    input  logic                 rx_byte_en,
    input  logic [7:0]           rx_byte,
    input  logic                 rx_eop,
    output logic                 rx_pid_en,
    output logic [3:0]           rx_pid,
    output logic [6:0]           rx_addr,
    output logic [3:0]           rx_endp,
    output logic                 rx_crc5_err,
    output logic                 rx_pkt_err,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [3:0] PidOut   = 4'b0001;
    localparam logic [3:0] PidIn    = 4'b1001;
    localparam logic [3:0] PidSetup = 4'b1101;
    localparam logic [3:0] PidSof   = 4'b0101;
    localparam logic [3:0] PidAck   = 4'b0010;
    localparam logic [3:0] PidNak   = 4'b1010;
    localparam logic [3:0] PidStall = 4'b1110;
    localparam logic [3:0] PidData0 = 4'b0011;
    localparam logic [3:0] PidData1 = 4'b1011;

    localparam logic [4:0] CrcInit     = 5'b11111;
    localparam logic [4:0] CrcPoly     = 5'b00101;
    localparam logic [4:0] CrcResidual = 5'b01100;

    localparam logic [2:0] CntMax   = 3'd7;
    localparam logic [2:0] CntToken = 3'(TOKEN_LEN);

    // The PID byte is decoded combinationally in its SOP cycle, so PID
    // classification never occupies a state of its own.
    typedef enum logic [1:0] {
        StIdle,
        StToken,
        StHs,
        StDiscard
    } state_e;

    state_e state_q, state_d;

    logic [2:0]           cnt_q, cnt_d;
    logic [4:0]           crc_q, crc_d;
    logic [3:0]           pkt_pid_q, pkt_pid_d;
    logic [7:0]           byte2_q, byte2_d;
    logic [2:0]           endp_hi_q, endp_hi_d;
    logic                 bad_q, bad_d;

    logic                 pid_en_q, pid_en_d;
    logic                 crc5_err_q, crc5_err_d;
    logic                 pkt_err_q, pkt_err_d;
    logic [3:0]           rx_pid_q, rx_pid_d;
    logic [6:0]           rx_addr_q, rx_addr_d;
    logic [3:0]           rx_endp_q, rx_endp_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [3:0] pid_in;
    logic       pid_ok;
    logic       pid_token;
    logic       pid_hs;
    logic       pid_data;
    logic       start;
    logic       pkt_byte;
    logic       addr_hit;

    // LSB-first serial CRC5 over one byte, unrolled into a single cycle.
    function automatic logic [4:0] crc5_byte(input logic [4:0] crc_in, input logic [7:0] data);
        logic [4:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            fb = c[4] ^ data[i];
            c  = {c[3:0], 1'b0} ^ (fb ? CrcPoly : 5'b00000);
        end
        return c;
    endfunction

    assign pid_in   = rx_byte[3:0];
    assign start    = rx_sop & rx_byte_en;
    assign pkt_byte = rx_byte_en & ~rx_sop & (state_q != StIdle);
    assign addr_hit = (byte2_q[6:0] == dev_addr) || (pkt_pid_q == PidSof);

    always_comb begin
        pid_ok    = (rx_byte[7:4] == ~rx_byte[3:0]);
        pid_token = 1'b0;
        pid_hs    = 1'b0;
        pid_data  = 1'b0;
        case (pid_in)
            PidOut, PidIn, PidSetup, PidSof: pid_token = 1'b1;
            PidAck, PidNak, PidStall:        pid_hs    = 1'b1;
            PidData0, PidData1:              pid_data  = 1'b1;
            default: ;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. A fresh SOP always wins, which both abandons a packet
    // in flight and lets an EOP+SOP cycle close the old packet and open a new one.
    always_comb begin
        state_d = state_q;
        if (start) begin
            if (!pid_ok) begin
                state_d = StDiscard;
            end else if (pid_token) begin
                state_d = StToken;
            end else if (pid_hs) begin
                state_d = StHs;
            end else begin
                state_d = StDiscard;
            end
        end else if (rx_eop) begin
            state_d = StIdle;
        end
    end

    // FSM: end-of-packet decision, registered so pulses trail EOP by one cycle.
    always_comb begin
        pid_en_d   = 1'b0;
        crc5_err_d = 1'b0;
        pkt_err_d  = 1'b0;
        if (rx_eop) begin
            case (state_q)
                StToken: begin
                    if (cnt_q != CntToken) begin
                        pkt_err_d = 1'b1;
                    end else if (crc_q != CrcResidual) begin
                        crc5_err_d = 1'b1;
                    end else if (!ms && addr_hit) begin
                        pid_en_d = 1'b1;
                    end
                end
                StHs: begin
                    if (cnt_q != 3'd1) begin
                        pkt_err_d = 1'b1;
                    end else if (rx_handshake_on) begin
                        pid_en_d = 1'b1;
                    end
                end
                StDiscard: pkt_err_d = bad_q;
                default: ;
            endcase
        end
    end

    // Packet datapath: byte counter, CRC and captured token fields.
    always_comb begin
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        pkt_pid_d = pkt_pid_q;
        byte2_d   = byte2_q;
        endp_hi_d = endp_hi_q;
        bad_d     = bad_q;
        if (start) begin
            cnt_d     = 3'd1;
            crc_d     = CrcInit;
            pkt_pid_d = pid_in;
            bad_d     = !pid_ok || !(pid_token || pid_hs || pid_data);
        end else if (rx_eop) begin
            cnt_d = 3'd0;
            crc_d = CrcInit;
            bad_d = 1'b0;
        end else if (pkt_byte) begin
            if (cnt_q != CntMax) begin
                cnt_d = cnt_q + 3'd1;
            end
            if (state_q == StToken) begin
                if (cnt_q == 3'd1) begin
                    crc_d   = crc5_byte(crc_q, rx_byte);
                    byte2_d = rx_byte;
                end else if (cnt_q == 3'd2) begin
                    crc_d     = crc5_byte(crc_q, rx_byte);
                    endp_hi_d = rx_byte[2:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 3'd0;
            crc_q     <= CrcInit;
            pkt_pid_q <= 4'd0;
            byte2_q   <= 8'd0;
            endp_hi_q <= 3'd0;
            bad_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            crc_q     <= crc_d;
            pkt_pid_q <= pkt_pid_d;
            byte2_q   <= byte2_d;
            endp_hi_q <= endp_hi_d;
            bad_q     <= bad_d;
        end
    end

    // Reported fields load only on accept; handshakes leave address/endpoint alone.
    always_comb begin
        rx_pid_d  = rx_pid_q;
        rx_addr_d = rx_addr_q;
        rx_endp_d = rx_endp_q;
        if (pid_en_d) begin
            rx_pid_d = pkt_pid_q;
            if (state_q == StToken) begin
                rx_addr_d = byte2_q[6:0];
                rx_endp_d = {endp_hi_q, byte2_q[7]};
            end
        end
    end

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if ((crc5_err_q || pkt_err_q) && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pid_en_q   <= 1'b0;
            crc5_err_q <= 1'b0;
            pkt_err_q  <= 1'b0;
            rx_pid_q   <= 4'd0;
            rx_addr_q  <= 7'd0;
            rx_endp_q  <= 4'd0;
            err_cnt_q  <= '0;
        end else begin
            pid_en_q   <= pid_en_d;
            crc5_err_q <= crc5_err_d;
            pkt_err_q  <= pkt_err_d;
            rx_pid_q   <= rx_pid_d;
            rx_addr_q  <= rx_addr_d;
            rx_endp_q  <= rx_endp_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rx_pid_en   = pid_en_q;
    assign rx_crc5_err = crc5_err_q;
    assign rx_pkt_err  = pkt_err_q;
    assign rx_pid      = rx_pid_q;
    assign rx_addr     = rx_addr_q;
    assign rx_endp     = rx_endp_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_crc5_r.sv
// Directed bench for crc5_r: hand-computed token/handshake vectors, boundary
// cases and error counter saturation; inputs change and outputs sample on negedge.
module tb_crc5_r;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ms;
    logic [6:0] dev_addr;
    logic       rx_handshake_on;
    logic       rx_sop;
    logic       rx_byte_en;
    logic [7:0] rx_byte;
    logic       rx_eop;
    logic       rx_pid_en;
    logic [3:0] rx_pid;
    logic [6:0] rx_addr;
    logic [3:0] rx_endp;
    logic       rx_crc5_err;
    logic       rx_pkt_err;
    logic       err_clr;
    logic [7:0] err_cnt;

    int n_chk = 0;
    int n_bad = 0;

    crc5_r #(
        .TOKEN_LEN(3),
        .ERR_CNT_W(8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ms             (ms),
        .dev_addr       (dev_addr),
        .rx_handshake_on(rx_handshake_on),
        .rx_sop         (rx_sop),
        .rx_byte_en     (rx_byte_en),
        .rx_byte        (rx_byte),
        .rx_eop         (rx_eop),
        .rx_pid_en      (rx_pid_en),
        .rx_pid         (rx_pid),
        .rx_addr        (rx_addr),
        .rx_endp        (rx_endp),
        .rx_crc5_err    (rx_crc5_err),
        .rx_pkt_err     (rx_pkt_err),
        .err_clr        (err_clr),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic sop, input logic be, input logic [7:0] b, input logic eop);
        @(negedge clk);
        rx_sop     = sop;
        rx_byte_en = be;
        rx_byte    = b;
        rx_eop     = eop;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send_eop();
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    task automatic send_bytes(input int n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        logic [7:0] v [5];
        v[0] = b0; v[1] = b1; v[2] = b2; v[3] = b3; v[4] = b4;
        for (int i = 0; i < n; i++) cyc((i == 0), 1'b1, v[i], 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ms = 1'b0; dev_addr = 7'd0; rx_handshake_on = 1'b0; err_clr = 1'b0;
        rx_sop = 1'b0; rx_byte_en = 1'b0; rx_byte = 8'h00; rx_eop = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (rx_pid_en !== 1'b0) begin n_bad++; $display("FAIL reset.pid_en got=%0b exp=0", rx_pid_en); end
        n_chk++; if (rx_pid !== 4'd0) begin n_bad++; $display("FAIL reset.pid got=%0h exp=0", rx_pid); end
        n_chk++; if (rx_addr !== 7'd0) begin n_bad++; $display("FAIL reset.addr got=%0h exp=0", rx_addr); end
        n_chk++; if (rx_endp !== 4'd0) begin n_bad++; $display("FAIL reset.endp got=%0h exp=0", rx_endp); end
        n_chk++; if (rx_crc5_err !== 1'b0) begin n_bad++; $display("FAIL reset.crc5 got=%0b exp=0", rx_crc5_err); end
        n_chk++; if (rx_pkt_err !== 1'b0) begin n_bad++; $display("FAIL reset.pkt got=%0b exp=0", rx_pkt_err); end
        n_chk++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset.err_cnt got=%0d exp=0", err_cnt); end
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_in_token();
        ms = 1'b0; dev_addr = 7'd0;
        send_bytes(3, 8'h69, 8'h00, 8'h10, 8'h00, 8'h00);
        send_eop();
        n_chk++; if (rx_pid_en !== 1'b0) begin n_bad++; $display("FAIL in.early got=%0b exp=0", rx_pid_en); end
        idle();
        n_chk++; if (rx_pid_en !== 1'b1) begin n_bad++; $display("FAIL in.pid_en got=%0b exp=1", rx_pid_en); end
        n_chk++; if (rx_pid !== 4'b1001) begin n_bad++; $display("FAIL in.pid got=%0h exp=9", rx_pid); end
        n_chk++; if (rx_addr !== 7'd0) begin n_bad++; $display("FAIL in.addr got=%0h exp=0", rx_addr); end
        n_chk++; if (rx_endp !== 4'd0) begin n_bad++; $display("FAIL in.endp got=%0h exp=0", rx_endp); end
        n_chk++; if ({rx_crc5_err, rx_pkt_err} !== 2'b00) begin n_bad++; $display("FAIL in.err got=%0b exp=0", {rx_crc5_err, rx_pkt_err}); end
        idle();
        n_chk++; if (rx_pid_en !== 1'b0) begin n_bad++; $display("FAIL in.single got=%0b exp=0", rx_pid_en); end
    endtask

    task automatic test_filter();
        dev_addr = 7'd5; ms = 1'b0;
        send_bytes(3, 8'h69, 8'h00, 8'h10, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if ({rx_pid_en, rx_crc5_err, rx_pkt_err} !== 3'b000) begin n_bad++; $display("FAIL filt.addr got=%0b exp=0", {rx_pid_en, rx_crc5_err, rx_pkt_err}); end
        dev_addr = 7'd0; ms = 1'b1;
        send_bytes(3, 8'h69, 8'h00, 8'h10, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if ({rx_pid_en, rx_crc5_err, rx_pkt_err} !== 3'b000) begin n_bad++; $display("FAIL filt.master got=%0b exp=0", {rx_pid_en, rx_crc5_err, rx_pkt_err}); end
        ms = 1'b0;
        idle();
    endtask

    task automatic test_sof_and_out();
        // SOF bypasses the address filter: dev_addr 0, token field 5/1.
        dev_addr = 7'd0;
        send_bytes(3, 8'hA5, 8'h85, 8'h60, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if (rx_pid_en !== 1'b1) begin n_bad++; $display("FAIL sof.pid_en got=%0b exp=1", rx_pid_en); end
        n_chk++; if (rx_pid !== 4'b0101) begin n_bad++; $display("FAIL sof.pid got=%0h exp=5", rx_pid); end
        n_chk++; if (rx_addr !== 7'd5) begin n_bad++; $display("FAIL sof.addr got=%0h exp=5", rx_addr); end
        n_chk++; if (rx_endp !== 4'd1) begin n_bad++; $display("FAIL sof.endp got=%0h exp=1", rx_endp); end
        idle();
        dev_addr = 7'd5;
        send_bytes(3, 8'hE1, 8'h85, 8'h60, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if (rx_pid_en !== 1'b1) begin n_bad++; $display("FAIL out.pid_en got=%0b exp=1", rx_pid_en); end
        n_chk++; if (rx_pid !== 4'b0001) begin n_bad++; $display("FAIL out.pid got=%0h exp=1", rx_pid); end
        idle();
    endtask

    task automatic test_crc_err();
        dev_addr = 7'd0;
        err_clr = 1'b1; idle(); err_clr = 1'b0; idle();
        send_bytes(3, 8'h2D, 8'h00, 8'h11, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if (rx_crc5_err !== 1'b1) begin n_bad++; $display("FAIL crc.crc5 got=%0b exp=1", rx_crc5_err); end
        n_chk++; if ({rx_pid_en, rx_pkt_err} !== 2'b00) begin n_bad++; $display("FAIL crc.other got=%0b exp=0", {rx_pid_en, rx_pkt_err}); end
        idle();
        n_chk++; if (err_cnt !== 8'd1) begin n_bad++; $display("FAIL crc.err_cnt got=%0d exp=1", err_cnt); end
        n_chk++; if (rx_crc5_err !== 1'b0) begin n_bad++; $display("FAIL crc.single got=%0b exp=0", rx_crc5_err); end
        n_chk++; if (rx_pid !== 4'b0001) begin n_bad++; $display("FAIL crc.pid_hold got=%0h exp=1", rx_pid); end
    endtask

    task automatic test_handshake();
        rx_handshake_on = 1'b1;
        send_bytes(1, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if (rx_pid_en !== 1'b1) begin n_bad++; $display("FAIL hs.pid_en got=%0b exp=1", rx_pid_en); end
        n_chk++; if (rx_pid !== 4'b0010) begin n_bad++; $display("FAIL hs.pid got=%0h exp=2", rx_pid); end
        n_chk++; if (rx_addr !== 7'd5) begin n_bad++; $display("FAIL hs.addr_hold got=%0h exp=5", rx_addr); end
        n_chk++; if (rx_endp !== 4'd1) begin n_bad++; $display("FAIL hs.endp_hold got=%0h exp=1", rx_endp); end
        idle();
        rx_handshake_on = 1'b0;
        send_bytes(1, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if ({rx_pid_en, rx_crc5_err, rx_pkt_err} !== 3'b000) begin n_bad++; $display("FAIL hs.window got=%0b exp=0", {rx_pid_en, rx_crc5_err, rx_pkt_err}); end
        rx_handshake_on = 1'b1;
        send_bytes(2, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if ({rx_pid_en, rx_pkt_err} !== 2'b01) begin n_bad++; $display("FAIL hs.len got=%0b exp=01", {rx_pid_en, rx_pkt_err}); end
        idle();
    endtask

    task automatic test_pkt_err();
        send_bytes(2, 8'h69, 8'h11, 8'h00, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if ({rx_pid_en, rx_crc5_err, rx_pkt_err} !== 3'b001) begin n_bad++; $display("FAIL pkt.short got=%0b exp=001", {rx_pid_en, rx_crc5_err, rx_pkt_err}); end
        idle();
        send_bytes(1, 8'h19, 8'h00, 8'h00, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if (rx_pkt_err !== 1'b1) begin n_bad++; $display("FAIL pkt.compl got=%0b exp=1", rx_pkt_err); end
        idle();
        send_bytes(1, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if (rx_pkt_err !== 1'b1) begin n_bad++; $display("FAIL pkt.reserved got=%0b exp=1", rx_pkt_err); end
        idle();
        send_bytes(5, 8'h4B, 8'h12, 8'h34, 8'h56, 8'h78);
        send_eop(); idle();
        n_chk++; if ({rx_pid_en, rx_crc5_err, rx_pkt_err} !== 3'b000) begin n_bad++; $display("FAIL pkt.data got=%0b exp=0", {rx_pid_en, rx_crc5_err, rx_pkt_err}); end
        idle();
        send_bytes(3, 8'h69, 8'h00, 8'h10, 8'h00, 8'h00);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0);
        send_eop(); idle();
        n_chk++; if ({rx_pid_en, rx_crc5_err, rx_pkt_err} !== 3'b001) begin n_bad++; $display("FAIL pkt.long got=%0b exp=001", {rx_pid_en, rx_crc5_err, rx_pkt_err}); end
        idle();
    endtask

    task automatic test_sop_mid();
        dev_addr = 7'd0; rx_handshake_on = 1'b1;
        send_bytes(3, 8'hA5, 8'h85, 8'h60, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if (rx_pid !== 4'b0101) begin n_bad++; $display("FAIL mid.pre_pid got=%0h exp=5", rx_pid); end
        idle();
        send_bytes(2, 8'hE1, 8'h00, 8'h00, 8'h00, 8'h00);
        send_bytes(1, 8'hD2, 8'h00, 8'h00, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if ({rx_pid_en, rx_crc5_err, rx_pkt_err} !== 3'b100) begin n_bad++; $display("FAIL mid.pulse got=%0b exp=100", {rx_pid_en, rx_crc5_err, rx_pkt_err}); end
        n_chk++; if (rx_pid !== 4'b0010) begin n_bad++; $display("FAIL mid.pid got=%0h exp=2", rx_pid); end
        idle();
        n_chk++; if ({rx_pid_en, rx_crc5_err, rx_pkt_err} !== 3'b000) begin n_bad++; $display("FAIL mid.single got=%0b exp=0", {rx_pid_en, rx_crc5_err, rx_pkt_err}); end
    endtask

    task automatic test_back_to_back();
        dev_addr = 7'd0; rx_handshake_on = 1'b1;
        send_bytes(3, 8'h69, 8'h00, 8'h10, 8'h00, 8'h00);
        cyc(1'b1, 1'b1, 8'hD2, 1'b1);
        idle();
        n_chk++; if (rx_pid_en !== 1'b1) begin n_bad++; $display("FAIL b2b.first got=%0b exp=1", rx_pid_en); end
        n_chk++; if (rx_pid !== 4'b1001) begin n_bad++; $display("FAIL b2b.first_pid got=%0h exp=9", rx_pid); end
        send_eop();
        n_chk++; if (rx_pid_en !== 1'b0) begin n_bad++; $display("FAIL b2b.gap got=%0b exp=0", rx_pid_en); end
        idle();
        n_chk++; if (rx_pid_en !== 1'b1) begin n_bad++; $display("FAIL b2b.second got=%0b exp=1", rx_pid_en); end
        n_chk++; if (rx_pid !== 4'b0010) begin n_bad++; $display("FAIL b2b.second_pid got=%0h exp=2", rx_pid); end
        idle();
    endtask

    task automatic test_idle_junk();
        cyc(1'b0, 1'b1, 8'hD2, 1'b0);
        send_eop(); idle();
        n_chk++; if ({rx_pid_en, rx_crc5_err, rx_pkt_err} !== 3'b000) begin n_bad++; $display("FAIL junk.pulse got=%0b exp=0", {rx_pid_en, rx_crc5_err, rx_pkt_err}); end
        idle();
        n_chk++; if ({rx_pid_en, rx_crc5_err, rx_pkt_err} !== 3'b000) begin n_bad++; $display("FAIL junk.after got=%0b exp=0", {rx_pid_en, rx_crc5_err, rx_pkt_err}); end
    endtask

    task automatic test_reset_mid();
        dev_addr = 7'd0;
        send_bytes(3, 8'h69, 8'h00, 8'h10, 8'h00, 8'h00);
        @(negedge clk); rst_n = 1'b0; rx_byte_en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        send_eop(); idle();
        n_chk++; if ({rx_pid_en, rx_crc5_err, rx_pkt_err} !== 3'b000) begin n_bad++; $display("FAIL rstmid.pulse got=%0b exp=0", {rx_pid_en, rx_crc5_err, rx_pkt_err}); end
        n_chk++; if (rx_pid !== 4'd0) begin n_bad++; $display("FAIL rstmid.pid got=%0h exp=0", rx_pid); end
        idle();
    endtask

    task automatic test_err_sat();
        for (int i = 0; i < 300; i++) begin
            send_bytes(3, 8'h2D, 8'h00, 8'h11, 8'h00, 8'h00);
            send_eop(); idle();
        end
        idle();
        n_chk++; if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat.err_cnt got=%0d exp=255", err_cnt); end
        send_bytes(3, 8'h2D, 8'h00, 8'h11, 8'h00, 8'h00);
        send_eop(); idle();
        n_chk++; if (rx_crc5_err !== 1'b1) begin n_bad++; $display("FAIL sat.crc5 got=%0b exp=1", rx_crc5_err); end
        err_clr = 1'b1;
        idle();
        err_clr = 1'b0;
        n_chk++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL sat.clr got=%0d exp=0", err_cnt); end
        idle();
        n_chk++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL sat.clr_hold got=%0d exp=0", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_in_token();
        test_filter();
        test_sof_and_out();
        test_crc_err();
        test_handshake();
        test_pkt_err();
        test_sop_mid();
        test_back_to_back();
        test_idle_junk();
        test_reset_mid();
        test_err_sat();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
